// File: rtl/wb_pkg.sv
// Shared constants for the write-back stage: source selects, load sizes and
// MEM/WB register field widths.
package wb_pkg;
  localparam int WB_SEL_W  = 2;
  localparam int LD_SIZE_W = 2;

  localparam logic [WB_SEL_W-1:0] WB_SEL_ALU = 2'b00;
  localparam logic [WB_SEL_W-1:0] WB_SEL_MEM = 2'b01;
  localparam logic [WB_SEL_W-1:0] WB_SEL_PC4 = 2'b10;

  localparam logic [LD_SIZE_W-1:0] LD_BYTE = 2'b00;
  localparam logic [LD_SIZE_W-1:0] LD_HALF = 2'b01;
  localparam logic [LD_SIZE_W-1:0] LD_WORD = 2'b10;
  localparam logic [LD_SIZE_W-1:0] LD_FULL = 2'b11;
endpackage

// File: rtl/wb_load_ext.sv
// Little-endian lane select and sign/zero extension of sub-word loads.
module wb_load_ext
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int BO_W   = $clog2(DATA_W/8)
) (
  input  logic [DATA_W-1:0]    mem_data,
  input  logic [LD_SIZE_W-1:0] ld_size,
  input  logic                 ld_unsigned,
  input  logic [BO_W-1:0]      byte_off,
  output logic [DATA_W-1:0]    ext_data
);
  localparam int MW = $clog2(DATA_W);
  localparam logic [BO_W-1:0] HALF_ALIGN = ~BO_W'(1);
  localparam logic [BO_W-1:0] WORD_ALIGN = ~BO_W'(3);

  logic [BO_W+2:0]   sh;
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] shifted;
  logic [MW-1:0]     msb;

  // Lane start is the offset rounded down to the lane size; DATA_W=32 words land on lane 0.
  always_comb begin
    sh       = '0;
    mask     = '1;
    msb      = MW'(DATA_W-1);
    shifted  = '0;
    ext_data = '0;
    case (ld_size)
      LD_BYTE: begin sh = {byte_off, 3'b000};              mask = DATA_W'(8'hFF);         msb = MW'(7);  end
      LD_HALF: begin sh = {byte_off & HALF_ALIGN, 3'b000}; mask = DATA_W'(16'hFFFF);      msb = MW'(15); end
      LD_WORD: begin sh = {byte_off & WORD_ALIGN, 3'b000}; mask = DATA_W'(32'hFFFF_FFFF); msb = MW'(31); end
      default: begin sh = '0;                              mask = '1;                     msb = MW'(DATA_W-1); end
    endcase
    shifted  = mem_data >> sh;
    ext_data = shifted & mask;
    if (!ld_unsigned && shifted[msb])
      ext_data = ext_data | ~mask;
  end
endmodule

// File: rtl/wb_stage_pipe.sv
// Write-back stage: MEM/WB register, source mux, register-file write and
// forwarding ports, saturating retired-instruction counter.
module wb_stage_pipe
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32,
  localparam int BO_W  = $clog2(DATA_W/8)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  input  logic                 i_stall,
  input  logic                 i_flush,
  input  logic [REG_AW-1:0]    i_write_reg,
  input  logic [DATA_W-1:0]    i_mem_data,
  input  logic [DATA_W-1:0]    i_result,
  input  logic [DATA_W-1:0]    i_pc_plus4,
  input  logic [WB_SEL_W-1:0]  i_wb_sel,
  input  logic                 i_reg_write,
  input  logic [LD_SIZE_W-1:0] i_ld_size,
  input  logic                 i_ld_unsigned,
  input  logic [BO_W-1:0]      i_byte_off,
  output logic [REG_AW-1:0]    o_write_reg,
  output logic [DATA_W-1:0]    o_write_data,
  output logic                 o_RegWrite,
  output logic                 o_fwd_valid,
  output logic [REG_AW-1:0]    o_fwd_reg,
  output logic [DATA_W-1:0]    o_fwd_data,
  output logic [CNT_W-1:0]     o_retired_cnt
);
  logic                 r_valid;
  logic [REG_AW-1:0]    r_write_reg;
  logic [DATA_W-1:0]    r_mem_data;
  logic [DATA_W-1:0]    r_result;
  logic [DATA_W-1:0]    r_pc_plus4;
  logic [WB_SEL_W-1:0]  r_wb_sel;
  logic                 r_reg_write;
  logic [LD_SIZE_W-1:0] r_ld_size;
  logic                 r_ld_unsigned;
  logic [BO_W-1:0]      r_byte_off;
  logic [CNT_W-1:0]     r_cnt;
  logic [DATA_W-1:0]    ld_ext;
  logic [DATA_W-1:0]    wb_data;
  logic                 departs;

  // The WB instruction leaves whenever the register is overwritten, including a flush under stall.
  assign departs = r_valid & (~i_stall | i_flush);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid       <= 1'b0;
      r_write_reg   <= '0;
      r_mem_data    <= '0;
      r_result      <= '0;
      r_pc_plus4    <= '0;
      r_wb_sel      <= '0;
      r_reg_write   <= 1'b0;
      r_ld_size     <= '0;
      r_ld_unsigned <= 1'b0;
      r_byte_off    <= '0;
      r_cnt         <= '0;
    end else begin
      if (i_flush) begin
        r_valid <= 1'b0;
      end else if (!i_stall) begin
        r_valid       <= i_valid;
        r_write_reg   <= i_write_reg;
        r_mem_data    <= i_mem_data;
        r_result      <= i_result;
        r_pc_plus4    <= i_pc_plus4;
        r_wb_sel      <= i_wb_sel;
        r_reg_write   <= i_reg_write;
        r_ld_size     <= i_ld_size;
        r_ld_unsigned <= i_ld_unsigned;
        r_byte_off    <= i_byte_off;
      end
      if (departs && (r_cnt != {CNT_W{1'b1}}))
        r_cnt <= r_cnt + 1'b1;
    end
  end

  wb_load_ext #(.DATA_W(DATA_W), .BO_W(BO_W)) u_load_ext (
    .mem_data    (r_mem_data),
    .ld_size     (r_ld_size),
    .ld_unsigned (r_ld_unsigned),
    .byte_off    (r_byte_off),
    .ext_data    (ld_ext)
  );

  always_comb begin
    case (r_wb_sel)
      WB_SEL_MEM: wb_data = ld_ext;
      WB_SEL_PC4: wb_data = r_pc_plus4;
      default:    wb_data = r_result;
    endcase
  end

  assign o_write_reg   = r_write_reg;
  assign o_write_data  = wb_data;
  assign o_RegWrite    = r_valid & r_reg_write & (r_write_reg != '0);
  assign o_fwd_valid   = o_RegWrite;
  assign o_fwd_reg     = r_write_reg;
  assign o_fwd_data    = wb_data;
  assign o_retired_cnt = r_cnt;
endmodule

// File: tb/tb_wb_stage_pipe.sv
// Randomised and directed bench for wb_stage_pipe against a behavioural model.
module tb_wb_stage_pipe;
  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0, i_stall = 1'b0, i_flush = 1'b0;
  logic [4:0]  i_write_reg = '0;
  logic [31:0] i_mem_data = '0, i_result = '0, i_pc_plus4 = '0;
  logic [1:0]  i_wb_sel = '0, i_ld_size = '0, i_byte_off = '0;
  logic        i_reg_write = 1'b0, i_ld_unsigned = 1'b0;

  logic [4:0]  o_write_reg, o_fwd_reg, p_write_reg, p_fwd_reg;
  logic [31:0] o_write_data, o_fwd_data, p_write_data, p_fwd_data;
  logic        o_RegWrite, o_fwd_valid, p_RegWrite, p_fwd_valid;
  logic [31:0] o_retired_cnt;
  logic [3:0]  p_retired_cnt;

  int checks = 0;
  int errors = 0;

  // behavioural model of the instruction sitting in WB
  bit          m_valid, m_rw, m_uns;
  logic [4:0]  m_reg;
  logic [31:0] m_mem, m_res, m_pc;
  logic [1:0]  m_sel, m_size, m_off;
  longint      m_cnt, m_cnt4;

  always #5 i_clk = ~i_clk;

  wb_stage_pipe #(.DATA_W(32), .REG_AW(5), .CNT_W(32)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_stall(i_stall), .i_flush(i_flush),
    .i_write_reg(i_write_reg), .i_mem_data(i_mem_data), .i_result(i_result), .i_pc_plus4(i_pc_plus4),
    .i_wb_sel(i_wb_sel), .i_reg_write(i_reg_write), .i_ld_size(i_ld_size), .i_ld_unsigned(i_ld_unsigned),
    .i_byte_off(i_byte_off), .o_write_reg(o_write_reg), .o_write_data(o_write_data),
    .o_RegWrite(o_RegWrite), .o_fwd_valid(o_fwd_valid), .o_fwd_reg(o_fwd_reg),
    .o_fwd_data(o_fwd_data), .o_retired_cnt(o_retired_cnt));

  wb_stage_pipe #(.DATA_W(32), .REG_AW(5), .CNT_W(4)) dut4 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_stall(i_stall), .i_flush(i_flush),
    .i_write_reg(i_write_reg), .i_mem_data(i_mem_data), .i_result(i_result), .i_pc_plus4(i_pc_plus4),
    .i_wb_sel(i_wb_sel), .i_reg_write(i_reg_write), .i_ld_size(i_ld_size), .i_ld_unsigned(i_ld_unsigned),
    .i_byte_off(i_byte_off), .o_write_reg(p_write_reg), .o_write_data(p_write_data),
    .o_RegWrite(p_RegWrite), .o_fwd_valid(p_fwd_valid), .o_fwd_reg(p_fwd_reg),
    .o_fwd_data(p_fwd_data), .o_retired_cnt(p_retired_cnt));

  function automatic logic [31:0] ref_load(logic [31:0] mem, logic [1:0] size, bit uns, logic [1:0] off);
    int bits, lane_bytes, start;
    longint v;
    bits       = (size == 2'd3) ? 32 : (8 << size);
    lane_bytes = bits / 8;
    start      = (int'(off) / lane_bytes) * lane_bytes;
    v          = (longint'(mem) >> (start * 8)) % (64'sd1 <<< bits);
    if (!uns && v >= (64'sd1 <<< (bits - 1))) v = v - (64'sd1 <<< bits);
    return v[31:0];
  endfunction

  function automatic logic [31:0] exp_data();
    case (m_sel)
      2'd1:    return ref_load(m_mem, m_size, m_uns, m_off);
      2'd2:    return m_pc;
      default: return m_res;
    endcase
  endfunction

  function automatic bit exp_we();
    return m_valid && m_rw && (m_reg != 5'd0);
  endfunction

  task automatic model_reset();
    m_valid = 0; m_rw = 0; m_uns = 0; m_reg = '0; m_mem = '0; m_res = '0; m_pc = '0;
    m_sel = '0; m_size = '0; m_off = '0; m_cnt = 0; m_cnt4 = 0;
  endtask

  task automatic tick();
    @(posedge i_clk);
    if (i_rst_n) begin
      if (m_valid && (!i_stall || i_flush)) begin
        if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
        if (m_cnt4 < 15) m_cnt4++;
      end
      if (i_flush) m_valid = 0;
      else if (!i_stall) begin
        m_valid = i_valid; m_reg = i_write_reg; m_mem = i_mem_data; m_res = i_result;
        m_pc = i_pc_plus4; m_sel = i_wb_sel; m_rw = i_reg_write; m_size = i_ld_size;
        m_uns = i_ld_unsigned; m_off = i_byte_off;
      end
    end
    #1;
  endtask

  task automatic drive(bit v, logic [4:0] rg, logic [31:0] mem, logic [31:0] res, logic [31:0] pc,
                       logic [1:0] sel, bit rw, logic [1:0] size, bit uns, logic [1:0] off);
    i_valid = v; i_write_reg = rg; i_mem_data = mem; i_result = res; i_pc_plus4 = pc;
    i_wb_sel = sel; i_reg_write = rw; i_ld_size = size; i_ld_unsigned = uns; i_byte_off = off;
    i_stall = 0; i_flush = 0;
  endtask

  task automatic test_reset();
    i_rst_n = 0; model_reset();
    repeat (2) tick();
    i_rst_n = 1;
    drive(1, 5'd9, '0, 32'hDEAD_BEEF, '0, 2'd0, 1, '0, 0, '0);
    tick(); tick();
    drive(0, '0, '0, '0, '0, '0, 0, '0, 0, '0);
    #2; i_rst_n = 0; #1; model_reset();
    checks++; if (o_RegWrite !== 1'b0 || o_fwd_valid !== 1'b0) begin errors++;
      $display("FAIL reset_we: got we=%b fwd=%b want 0/0", o_RegWrite, o_fwd_valid); end
    checks++; if (o_write_reg !== 5'd0 || o_write_data !== 32'd0) begin errors++;
      $display("FAIL reset_data: got reg=%0d data=%h want 0/0", o_write_reg, o_write_data); end
    checks++; if (o_retired_cnt !== 32'd0 || p_retired_cnt !== 4'd0) begin errors++;
      $display("FAIL reset_cnt: got %0d/%0d want 0/0", o_retired_cnt, p_retired_cnt); end
    tick(); i_rst_n = 1;
  endtask

  task automatic test_alu();
    longint c0 = m_cnt;
    drive(1, 5'd5, '0, 32'h1234_5678, '0, 2'd0, 1, '0, 0, '0);
    tick();
    drive(0, '0, '0, '0, '0, '0, 0, '0, 0, '0);
    checks++; if (o_write_data !== 32'h1234_5678 || o_write_reg !== 5'd5 || o_RegWrite !== 1'b1) begin errors++;
      $display("FAIL alu_write: got data=%h reg=%0d we=%b want 12345678/5/1", o_write_data, o_write_reg, o_RegWrite); end
    tick();
    checks++; if (o_retired_cnt !== 32'(c0 + 1)) begin errors++;
      $display("FAIL alu_cnt: got %0d want %0d", o_retired_cnt, c0 + 1); end
  endtask

  task automatic test_load_ext();
    logic [1:0]  sz[4]  = '{2'd0, 2'd0, 2'd1, 2'd1};
    bit          un[4]  = '{0, 1, 0, 1};
    logic [1:0]  of[4]  = '{2'd0, 2'd1, 2'd2, 2'd3};
    logic [31:0] ex[4]  = '{32'hFFFF_FF81, 32'h0000_007F, 32'hFFFF_80FF, 32'h0000_80FF};
    for (int k = 0; k < 4; k++) begin
      drive(1, 5'd7, 32'h80FF_7F81, 32'h5555_5555, '0, 2'd1, 1, sz[k], un[k], of[k]);
      tick();
      checks++; if (o_write_data !== ex[k] || o_fwd_data !== ex[k]) begin errors++;
        $display("FAIL load_ext_%0d: got %h/%h want %h", k, o_write_data, o_fwd_data, ex[k]); end
    end
  endtask

  task automatic test_reg0_pc4();
    drive(1, 5'd0, '0, 32'hAAAA_0000, '0, 2'd0, 1, '0, 0, '0);
    tick();
    checks++; if (o_RegWrite !== 1'b0 || o_fwd_valid !== 1'b0) begin errors++;
      $display("FAIL reg_zero: got we=%b fwd=%b want 0/0", o_RegWrite, o_fwd_valid); end
    drive(1, 5'd31, '0, 32'h1111_1111, 32'h0000_0044, 2'd2, 1, '0, 0, '0);
    tick();
    checks++; if (o_write_data !== 32'h44 || o_fwd_reg !== 5'd31 || o_fwd_data !== 32'h44 || o_fwd_valid !== 1'b1) begin errors++;
      $display("FAIL pc4: got data=%h reg=%0d fwd=%h v=%b want 44/31/44/1", o_write_data, o_fwd_reg, o_fwd_data, o_fwd_valid); end
  endtask

  task automatic test_stall_flush();
    longint c0;
    drive(1, 5'd12, '0, 32'hCAFE_F00D, '0, 2'd0, 1, '0, 0, '0);
    tick();
    c0 = m_cnt;
    drive(1, 5'd3, '0, 32'h0BAD_0BAD, '0, 2'd0, 1, '0, 0, '0);
    i_stall = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (o_write_data !== 32'hCAFE_F00D || o_write_reg !== 5'd12 || o_RegWrite !== 1'b1) begin errors++;
        $display("FAIL stall_hold_%0d: got data=%h reg=%0d we=%b want cafef00d/12/1", k, o_write_data, o_write_reg, o_RegWrite); end
      checks++; if (o_retired_cnt !== 32'(c0)) begin errors++;
        $display("FAIL stall_cnt_%0d: got %0d want %0d", k, o_retired_cnt, c0); end
    end
    i_flush = 1;
    tick();
    checks++; if (o_RegWrite !== 1'b0 || o_fwd_valid !== 1'b0) begin errors++;
      $display("FAIL flush_valid: got we=%b fwd=%b want 0/0", o_RegWrite, o_fwd_valid); end
    checks++; if (o_retired_cnt !== 32'(c0 + 1)) begin errors++;
      $display("FAIL flush_cnt: got %0d want %0d", o_retired_cnt, c0 + 1); end
    drive(0, '0, '0, '0, '0, '0, 0, '0, 0, '0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      drive($urandom_range(0, 3) != 0, 5'($urandom), $urandom, $urandom, $urandom,
            2'($urandom), $urandom_range(0, 1), 2'($urandom), $urandom_range(0, 1), 2'($urandom));
      i_stall = ($urandom_range(0, 3) == 0);
      i_flush = ($urandom_range(0, 7) == 0);
      tick();
      checks++; if (o_RegWrite !== exp_we() || o_fwd_valid !== exp_we()) begin errors++;
        $display("FAIL rnd_we_%0d: got %b/%b want %b", k, o_RegWrite, o_fwd_valid, exp_we()); end
      if (m_valid) begin
        checks++; if (o_write_data !== exp_data() || o_fwd_data !== exp_data() || o_write_reg !== m_reg || o_fwd_reg !== m_reg) begin errors++;
          $display("FAIL rnd_data_%0d: got %h/%h reg %0d want %h reg %0d (sel=%0d sz=%0d u=%0d off=%0d mem=%h)",
                   k, o_write_data, o_fwd_data, o_write_reg, exp_data(), m_reg, m_sel, m_size, m_uns, m_off, m_mem); end
      end
      checks++; if (o_retired_cnt !== 32'(m_cnt) || p_retired_cnt !== 4'(m_cnt4)) begin errors++;
        $display("FAIL rnd_cnt_%0d: got %0d/%0d want %0d/%0d", k, o_retired_cnt, p_retired_cnt, m_cnt, m_cnt4); end
    end
    drive(0, '0, '0, '0, '0, '0, 0, '0, 0, '0);
    tick();
  endtask

  task automatic test_saturation();
    #2; i_rst_n = 0; #1; model_reset(); tick(); i_rst_n = 1;
    for (int k = 0; k < 20; k++) begin
      drive(1, 5'(k + 1), '0, 32'(k), '0, 2'd0, 1, '0, 0, '0);
      tick();
    end
    drive(0, '0, '0, '0, '0, '0, 0, '0, 0, '0);
    tick();
    checks++; if (p_retired_cnt !== 4'd15 || o_retired_cnt !== 32'd20) begin errors++;
      $display("FAIL saturate: got %0d/%0d want 15/20", p_retired_cnt, o_retired_cnt); end
    for (int k = 0; k < 3; k++) begin
      drive(1, 5'd2, '0, '0, '0, 2'd0, 1, '0, 0, '0);
      tick();
    end
    drive(0, '0, '0, '0, '0, '0, 0, '0, 0, '0);
    tick();
    checks++; if (p_retired_cnt !== 4'd15 || o_retired_cnt !== 32'd23) begin errors++;
      $display("FAIL saturate_hold: got %0d/%0d want 15/23", p_retired_cnt, o_retired_cnt); end
  endtask

  task automatic test_reset_mid_stall();
    drive(1, 5'd20, '0, 32'h7777_7777, '0, 2'd0, 1, '0, 0, '0);
    tick();
    i_stall = 1;
    tick(); tick();
    #2; i_rst_n = 0; #1; model_reset();
    checks++; if (o_RegWrite !== 1'b0 || o_retired_cnt !== 32'd0 || o_write_data !== 32'd0) begin errors++;
      $display("FAIL rst_stall: got we=%b cnt=%0d data=%h want 0/0/0", o_RegWrite, o_retired_cnt, o_write_data); end
    tick(); i_rst_n = 1;
    drive(0, '0, '0, '0, '0, '0, 0, '0, 0, '0);
    tick(); tick();
    checks++; if (o_retired_cnt !== 32'd0 || p_retired_cnt !== 4'd0) begin errors++;
      $display("FAIL rst_stall_drop: got %0d/%0d want 0/0", o_retired_cnt, p_retired_cnt); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_ext();
    test_reg0_pc4();
    test_stall_flush();
    test_random();
    test_saturation();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
